// File: rtl/seven_seg_scan_if.sv
// Bus between a result-register block and the 7-segment scan driver.
// master drives the display data; slave is the scan driver that owns the pins.
interface seven_seg_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic [DIGITS-1:0]   blank_mask;
    logic [DIGITS-1:0]   dp;
    logic [6:0]          seg;
    logic                seg_dp;
    logic [DIGITS-1:0]   dig_sel;
    logic                frame_tick;

    modport master (
        output value, load, blank_mask, dp,
        input  seg, seg_dp, dig_sel, frame_tick
    );

    modport slave (
        input  value, load, blank_mask, dp,
        output seg, seg_dp, dig_sel, frame_tick
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed hex 7-segment driver with frame-synchronous shadow commit.
// Optional ghost blanking at the start of each slot: define SEVSEG_GHOST_BLANK_EN.
module seven_seg_scan #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    parameter int BLANK_CYCLES   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    seven_seg_scan_if.slave   bus
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF    = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] DIG_OFF    = {DIGITS{DIG_ACTIVE_LOW}};

    logic [PW-1:0]       r_presc;
    logic [IW-1:0]       r_idx;
    logic [4*DIGITS-1:0] r_shadow;
    logic [4*DIGITS-1:0] r_pending;
    logic                r_pend_flag;
    logic [6:0]          r_seg;
    logic                r_seg_dp;
    logic [DIGITS-1:0]   r_dig_sel;
    logic                r_frame_tick;

    logic                w_terminal;
    logic                w_wrap;
    logic                w_ghost;
    logic                w_blank;
    logic [3:0]          w_nibble;
    logic [DIGITS-1:0]   w_onehot;
    logic [6:0]          w_seg_pin;
    logic                w_dp_pin;
    logic [DIGITS-1:0]   w_dig_pin;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign w_terminal = (r_presc == PRESC_LAST);
    assign w_wrap     = w_terminal && (r_idx == IDX_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_onehot
            assign w_onehot[gi] = (r_idx == IW'(gi));
        end
    endgenerate

`ifdef SEVSEG_GHOST_BLANK_EN
    assign w_ghost = (r_presc < PW'(BLANK_CYCLES));
`else
    assign w_ghost = 1'b0;
`endif

    // Blanking is live: mask and ghost window act on the slot currently being scanned.
    always_comb begin
        w_nibble  = r_shadow[4*r_idx +: 4];
        w_blank   = bus.blank_mask[r_idx] | w_ghost;
        w_seg_pin = hex_to_seg(w_nibble) ^ SEG_OFF;
        w_dp_pin  = bus.dp[r_idx] ^ SEG_ACTIVE_LOW;
        w_dig_pin = w_onehot ^ DIG_OFF;
        if (w_blank) begin
            w_seg_pin = SEG_OFF;
            w_dp_pin  = SEG_ACTIVE_LOW;
            w_dig_pin = DIG_OFF;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_terminal ? '0 : r_presc + 1'b1;
            if (w_terminal) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // A load landing on the wrap cycle goes straight to the shadow so it is not lost a frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow    <= '0;
            r_pending   <= '0;
            r_pend_flag <= 1'b0;
        end else if (w_wrap && bus.load) begin
            r_shadow    <= bus.value;
            r_pending   <= bus.value;
            r_pend_flag <= 1'b0;
        end else if (w_wrap && r_pend_flag) begin
            r_shadow    <= r_pending;
            r_pend_flag <= 1'b0;
        end else if (bus.load) begin
            r_pending   <= bus.value;
            r_pend_flag <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg        <= SEG_OFF;
            r_seg_dp     <= SEG_ACTIVE_LOW;
            r_dig_sel    <= DIG_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_seg        <= w_seg_pin;
            r_seg_dp     <= w_dp_pin;
            r_dig_sel    <= w_dig_pin;
            r_frame_tick <= w_wrap;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.seg_dp     = r_seg_dp;
    assign bus.dig_sel    = r_dig_sel;
    assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomized bench for seven_seg_scan against a frame-level reference model.
// Define SEVSEG_GHOST_BLANK_EN to exercise the ghost-blank build (BLANK_CYCLES=1).
module tb_seven_seg_scan;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = DIGITS * SCAN_DIV;
`ifdef SEVSEG_GHOST_BLANK_EN
    localparam int BLANK_CYCLES = 1;
`else
    localparam int BLANK_CYCLES = 2;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_seg_scan_if #(.DIGITS(DIGITS)) bus ();

    seven_seg_scan #(
        .DIGITS        (DIGITS),
        .SCAN_DIV      (SCAN_DIV),
        .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b1),
        .BLANK_CYCLES  (BLANK_CYCLES)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    typedef struct {
        int          cyc;
        logic [15:0] val;
    } load_t;

    load_t      loads[$];
    int         k = 0;
    int         total = 0;
    int         bad = 0;
    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, k);
        end
    endtask

    // Value on the display during frame f: the last load captured strictly before that frame.
    function automatic logic [15:0] shown_at(input int f);
        logic [15:0] v;
        v = 16'h0000;
        foreach (loads[i]) begin
            if (loads[i].cyc < f * FRAME) v = loads[i].val;
        end
        return v;
    endfunction

    task automatic step(input logic ld, input logic [15:0] val,
                        input logic [3:0] bm, input logic [3:0] dpv);
        int          idx;
        int          slot_cyc;
        logic [15:0] fr;
        logic [3:0]  nib;
        logic        blank;
        logic [3:0]  onehot;
        logic [6:0]  exp_seg;
        logic        exp_dp;
        logic [3:0]  exp_dig;
        logic        exp_tick;
        bus.load       = ld;
        bus.value      = val;
        bus.blank_mask = bm;
        bus.dp         = dpv;
        @(posedge clk);
        #1;
        idx      = (k / SCAN_DIV) % DIGITS;
        slot_cyc = k % SCAN_DIV;
        fr       = shown_at(k / FRAME);
        nib      = fr[4*idx +: 4];
        blank    = bm[idx];
`ifdef SEVSEG_GHOST_BLANK_EN
        if (slot_cyc < BLANK_CYCLES) blank = 1'b1;
`endif
        onehot   = 4'b0001 << idx;
        exp_seg  = blank ? 7'h7F : ~hex_tab[nib];
        exp_dp   = blank ? 1'b1 : ~dpv[idx];
        exp_dig  = blank ? 4'hF : ~onehot;
        exp_tick = ((k % FRAME) == FRAME - 1);
        chk_eq("seg",        32'(bus.seg),        32'(exp_seg));
        chk_eq("seg_dp",     32'(bus.seg_dp),     32'(exp_dp));
        chk_eq("dig_sel",    32'(bus.dig_sel),    32'(exp_dig));
        chk_eq("frame_tick", 32'(bus.frame_tick), 32'(exp_tick));
        $display("cyc=%0d slot=%0d.%0d ld=%b val=%h dig_sel=%h seg=%h dp=%b tick=%b",
                 k, idx, slot_cyc, ld, val, bus.dig_sel, bus.seg, bus.seg_dp, bus.frame_tick);
        if (ld) loads.push_back('{k, val});
        k++;
    endtask

    task automatic check_inactive(input string tag);
        chk_eq({tag, "_seg"},    32'(bus.seg),        32'h7F);
        chk_eq({tag, "_dp"},     32'(bus.seg_dp),     32'h1);
        chk_eq({tag, "_dig"},    32'(bus.dig_sel),    32'hF);
        chk_eq({tag, "_tick"},   32'(bus.frame_tick), 32'h0);
    endtask

    initial begin
        bus.load       = 1'b0;
        bus.value      = 16'h0000;
        bus.blank_mask = 4'h0;
        bus.dp         = 4'h0;

        repeat (3) @(posedge clk);
        #1;
        check_inactive("reset");
        rst_n = 1'b1;
        k = 0;
        loads.delete();

        // Directed: commit at wrap, mid-frame load, load on the wrap cycle, blank/dp.
        for (int c = 0; c < 80; c++) begin
            logic        ld;
            logic [15:0] v;
            logic [3:0]  bm;
            logic [3:0]  dpv;
            ld  = (c == 0) || (c == 21) || (c == 47);
            v   = (c == 0) ? 16'h12AF : ((c == 47) ? 16'h5E3C : 16'h0000);
            bm  = (c >= 48) ? 4'b0100 : 4'b0000;
            dpv = (c >= 48) ? 4'b0001 : 4'b0000;
            step(ld, v, bm, dpv);
        end

        for (int c = 0; c < 400; c++) begin
            logic        ld;
            logic [3:0]  bm;
            ld = ($urandom_range(0, 7) == 0);
            bm = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            step(ld, 16'($urandom), bm, 4'($urandom));
        end

        // Leave a pending load outstanding, then reset in the middle of slot 2.
        while ((k % FRAME) != 2 * SCAN_DIV + 2) begin
            step(1'b1, 16'hBEEF, 4'h0, 4'h0);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_inactive("midrst");
        @(posedge clk);
        #1;
        check_inactive("midrst_hold");
        rst_n = 1'b1;
        k = 0;
        loads.delete();

        for (int c = 0; c < 40; c++) begin
            step(1'b0, 16'h0000, 4'h0, 4'h0);
        end
        for (int c = 0; c < 100; c++) begin
            step(($urandom_range(0, 5) == 0), 16'($urandom), 4'h0, 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
